fifo_wconv_sync: RTL and testbench

Single-clock FIFO with parametrised write-to-read width expansion. It accepts `DW_IN`-bit words and delivers `RATIO` of them packed into one read word, with programmable almost-empty/almost-full thresholds, an occupancy count and overflow/underflow error pulses. It is the generalised fabric replacement for the fixed 1k×9 → 18-bit FIFO primitive in the north bridge. It serves byte-plus-tag streams feeding wider NN datapaths where both sides share one clock.

---
 rtl/fifo_pkg.sv | 36 +++
 rtl/fifo_bank_ram.sv | 26 ++
 rtl/fifo_wconv_sync.sv | 115 +++++++++++
 tb/tb_fifo_wconv_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Sizing helpers and parameter legality checks for the width-converting FIFO.
package fifo_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit ratio_legal(input int r);
      return (r == 1) || (r == 2) || (r == 4);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Write pointer indexes write words; read pointer indexes packed rows.
   function automatic int ptr_w(input int depth);
      return clog2(depth);
   endfunction

   function automatic int row_w(input int depth, input int ratio);
      return clog2(depth / ratio);
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2(depth) + 1;
   endfunction

   function automatic int lane_w(input int ratio);
      return (ratio > 1) ? clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/fifo_bank_ram.sv
// One lane of FIFO storage: simple dual-port RAM, synchronous read, no reset.
// Read data lands one edge after re; no backpressure (caller gates we/re).
module fifo_bank_ram
   import fifo_pkg::*;
#(
   parameter int DW   = 9,
   parameter int ROWS = 512,
   parameter int AW   = clog2(ROWS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdat,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdat
);

   logic [DW-1:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
      if (re) rdat <= mem[raddr];
   end

endmodule

// File: rtl/fifo_wconv_sync.sv
// Single-clock FIFO packing RATIO write words into one read word, earliest word in the MSB lane.
// Read latency 1 (no FWFT); writes rejected when full, reads rejected until a whole row is stored.
module fifo_wconv_sync
   import fifo_pkg::*;
#(
   parameter int DW_IN = 9,
   parameter int RATIO = 2,
   parameter int DEPTH = 1024,
   parameter int AE_TH = 13,
   parameter int AF_TH = 1016
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DW_IN-1:0]          di,
   input  logic                      we,
   input  logic                      re,
   output logic [DW_IN*RATIO-1:0]    rd_dat,
   output logic                      empty_flag,
   output logic                      full_flag,
   output logic                      aempty_flag,
   output logic                      afull_flag,
   output logic [cnt_w(DEPTH)-1:0]   level,
   output logic                      wr_err,
   output logic                      rd_err
);

   localparam int DW_OUT = DW_IN * RATIO;
   localparam int ROWS   = DEPTH / RATIO;
   localparam int PW     = ptr_w(DEPTH);
   localparam int RW     = row_w(DEPTH, RATIO);
   localparam int LW     = lane_w(RATIO);
   localparam int CW     = cnt_w(DEPTH);

   if (!ratio_legal(RATIO)) begin : g_bad_ratio
      $error("fifo_wconv_sync: RATIO must be 1, 2 or 4");
   end
   if (!is_pow2(DEPTH) || DEPTH < 2 * RATIO) begin : g_bad_depth
      $error("fifo_wconv_sync: DEPTH must be a power of two and at least 2*RATIO");
   end
   if (!(AE_TH < AF_TH && AF_TH <= DEPTH)) begin : g_bad_thresh
      $error("fifo_wconv_sync: thresholds must satisfy AE_TH < AF_TH <= DEPTH");
   end
   if (DW_IN < 1) begin : g_bad_width
      $error("fifo_wconv_sync: DW_IN must be at least 1");
   end

   logic [PW-1:0]    wptr;
   logic [RW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             out_vld;
   logic             wacc;
   logic             racc;
   logic [LW-1:0]    wlane;
   logic [RW-1:0]    wrow;
   logic [DW_IN-1:0] bank_dat [RATIO];

   assign full_flag   = (count == CW'(DEPTH));
   assign empty_flag  = (count < CW'(RATIO));
   assign aempty_flag = (count <= CW'(AE_TH));
   assign afull_flag  = (count >= CW'(AF_TH));
   assign level       = count;

   assign wacc  = we && !full_flag && !rst;
   assign racc  = re && !empty_flag && !rst;
   assign wlane = LW'(32'(wptr) % RATIO);
   assign wrow  = RW'(32'(wptr) / RATIO);

   // While a reader holds rptr's row, the writer is always on a different row, so no bypass is needed.
   for (genvar k = 0; k < RATIO; k++) begin : g_bank
      fifo_bank_ram #(
         .DW   (DW_IN),
         .ROWS (ROWS),
         .AW   (RW)
      ) u_ram (
         .clk   (clk),
         .we    (wacc && (wlane == LW'(k))),
         .waddr (wrow),
         .wdat  (di),
         .re    (racc),
         .raddr (rptr),
         .rdat  (bank_dat[k])
      );
   end

   // The RAM read registers are not reset, so out_vld masks them until the first accepted read.
   always_comb begin
      rd_dat = '0;
      if (out_vld) begin
         for (int k = 0; k < RATIO; k++) begin
            rd_dat[DW_OUT-1-k*DW_IN -: DW_IN] = bank_dat[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         out_vld <= 1'b0;
         wr_err  <= 1'b0;
         rd_err  <= 1'b0;
      end else begin
         if (wacc) wptr <= wptr + PW'(1);
         if (racc) begin
            rptr    <= rptr + RW'(1);
            out_vld <= 1'b1;
         end
         count  <= count + CW'(wacc) - (racc ? CW'(RATIO) : CW'(0));
         wr_err <= we && full_flag;
         rd_err <= re && empty_flag;
      end
   end

endmodule

// File: tb/tb_fifo_wconv_sync.sv
// Bench for fifo_wconv_sync: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fifo_wconv_sync;

   localparam int DW_IN  = 9;
   localparam int RATIO  = 2;
   localparam int DEPTH  = 1024;
   localparam int AE_TH  = 13;
   localparam int AF_TH  = 1016;
   localparam int DW_OUT = DW_IN * RATIO;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we  = 1'b0;
   logic              re  = 1'b0;
   logic [DW_IN-1:0]  di  = '0;
   logic [DW_OUT-1:0] rd_dat;
   logic              empty_flag, full_flag, aempty_flag, afull_flag;
   logic [10:0]       level;
   logic              wr_err, rd_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_wconv_sync #(
      .DW_IN (DW_IN),
      .RATIO (RATIO),
      .DEPTH (DEPTH),
      .AE_TH (AE_TH),
      .AF_TH (AF_TH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .di          (di),
      .we          (we),
      .re          (re),
      .rd_dat      (rd_dat),
      .empty_flag  (empty_flag),
      .full_flag   (full_flag),
      .aempty_flag (aempty_flag),
      .afull_flag  (afull_flag),
      .level       (level),
      .wr_err      (wr_err),
      .rd_err      (rd_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of write words; a read pops RATIO words, first popped in the MSB lane.
   logic [DW_IN-1:0]  mq[$];
   logic [DW_OUT-1:0] m_do     = '0;
   bit                m_wr_err = 1'b0;
   bit                m_rd_err = 1'b0;
   bit                live     = 1'b0;
   bit                wa, ra;
   int                mn;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_do     = '0;
         m_wr_err = 1'b0;
         m_rd_err = 1'b0;
         live     = 1'b1;
      end else begin
         wa = we && (mq.size() < DEPTH);
         ra = re && (mq.size() >= RATIO);
         m_wr_err = we && !wa;
         m_rd_err = re && !ra;
         if (ra) begin
            m_do = '0;
            for (int k = 0; k < RATIO; k++) m_do = {m_do[DW_OUT-DW_IN-1:0], mq.pop_front()};
         end
         if (wa) mq.push_back(di);
      end
   end

   always @(posedge clk) begin
      #1;
      if (live) begin
         mn = mq.size();
         chk("model_level",  32'(level),       32'(mn));
         chk("model_empty",  32'(empty_flag),  32'(mn < RATIO));
         chk("model_full",   32'(full_flag),   32'(mn == DEPTH));
         chk("model_aempty", 32'(aempty_flag), 32'(mn <= AE_TH));
         chk("model_afull",  32'(afull_flag),  32'(mn >= AF_TH));
         chk("model_do",     32'(rd_dat),      32'(m_do));
         chk("model_wr_err", 32'(wr_err),      32'(m_wr_err));
         chk("model_rd_err", 32'(rd_err),      32'(m_rd_err));
      end
   end

   task automatic cyc(input logic w, input logic r, input logic [DW_IN-1:0] d);
      we = w;
      re = r;
      di = d;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   logic [DW_IN-1:0] wa9, wb9;

   initial begin
      // Reset values, then a lone word is not readable
      do_reset();
      chk("rst_level",  32'(level),       32'd0);
      chk("rst_empty",  32'(empty_flag),  32'd1);
      chk("rst_aempty", 32'(aempty_flag), 32'd1);
      chk("rst_full",   32'(full_flag),   32'd0);
      chk("rst_afull",  32'(afull_flag),  32'd0);
      chk("rst_do",     32'(rd_dat),      32'd0);
      chk("rst_errs",   32'({wr_err, rd_err}), 32'd0);
      cyc(1'b1, 1'b0, 9'h055);
      cyc(1'b0, 1'b1, '0);
      chk("uf_rd_err", 32'(rd_err), 32'd1);
      chk("uf_do",     32'(rd_dat), 32'd0);
      chk("uf_level",  32'(level),  32'd1);
      cyc(1'b0, 1'b0, '0);
      chk("uf_rd_err_clr", 32'(rd_err), 32'd0);

      // Two words, one read
      do_reset();
      cyc(1'b1, 1'b0, 9'h101);
      chk("s1_level1", 32'(level), 32'd1);
      chk("s1_empty1", 32'(empty_flag), 32'd1);
      cyc(1'b1, 1'b0, 9'h0AB);
      chk("s1_level2", 32'(level), 32'd2);
      chk("s1_empty2", 32'(empty_flag), 32'd0);
      cyc(1'b0, 1'b1, '0);
      chk("s1_do",     32'(rd_dat), 32'h202AB);
      chk("s1_level3", 32'(level), 32'd0);
      chk("s1_empty3", 32'(empty_flag), 32'd1);

      // Fill to DEPTH, overflow, then simultaneous read/write while full
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 1'b0, 9'(i * 7 + 3));
         if (i >= 1010) begin
            chk("fill_afull", 32'(afull_flag), 32'((i + 1) >= AF_TH));
            chk("fill_full",  32'(full_flag),  32'((i + 1) == DEPTH));
         end
      end
      cyc(1'b1, 1'b0, 9'h1EE);
      chk("of_wr_err", 32'(wr_err), 32'd1);
      chk("of_level",  32'(level),  32'd1024);
      cyc(1'b1, 1'b1, 9'h1FF);
      chk("fullrw_level",  32'(level),  32'd1022);
      chk("fullrw_wr_err", 32'(wr_err), 32'd1);
      chk("fullrw_rd_err", 32'(rd_err), 32'd0);
      chk("fullrw_do",     32'(rd_dat), 32'h0060A);

      // Streaming around level 2..3 across pointer wrap
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 9'(i));
      for (int i = 0; i < 2000; i++) begin
         cyc(1'b1, (i % 2) == 0, 9'(i + 3));
         chk("str_level", 32'(level), (i % 2 == 0) ? 32'd2 : 32'd3);
         chk("str_errs",  32'({wr_err, rd_err}), 32'd0);
         if (i % 2 == 0) begin
            wa9 = 9'(i);
            wb9 = 9'(i + 1);
            chk("str_do", 32'(rd_dat), 32'({wa9, wb9}));
         end
      end

      // Reset mid-stream with a write pending
      do_reset();
      for (int i = 0; i < 502; i++) cyc(1'b1, 1'b0, 9'(i));
      cyc(1'b0, 1'b1, '0);
      chk("mr_pre_do",    32'(rd_dat), 32'h00001);
      chk("mr_pre_level", 32'(level),  32'd500);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 9'h0AA);
      rst = 1'b0;
      chk("mr_level", 32'(level),      32'd0);
      chk("mr_empty", 32'(empty_flag), 32'd1);
      chk("mr_do",    32'(rd_dat),     32'd0);
      cyc(1'b1, 1'b0, 9'h1C3);
      cyc(1'b1, 1'b0, 9'h02D);
      cyc(1'b0, 1'b1, '0);
      chk("mr_new_do",    32'(rd_dat), 32'h3862D);
      chk("mr_new_level", 32'(level),  32'd0);
      cyc(1'b0, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
